// File: rtl/seq_magnitude_comparator_if.sv
// Request/result bundle for the serial magnitude comparator: operands and
// cascade inputs travel from the requester, status and verdict flow back.
interface seq_magnitude_comparator_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             Gi;
    logic             Ei;
    logic             Li;
    logic             busy;
    logic             done;
    logic             Go;
    logic             Eo;
    logic             Lo;

    modport master (
        output start, a, b, Gi, Ei, Li,
        input  busy, done, Go, Eo, Lo
    );

    modport slave (
        input  start, a, b, Gi, Ei, Li,
        output busy, done, Go, Eo, Lo
    );
endinterface

// File: rtl/seq_magnitude_comparator.sv
// Serial, cascadable unsigned magnitude comparator. Walks the operands one
// DIGIT-bit slice per clock, most-significant first, and stops at the first
// slice that differs. A cleared cascade-equal input short-circuits the walk
// and forwards the upstream greater/less verdict untouched.
module seq_magnitude_comparator #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    seq_magnitude_comparator_if.slave   bus
);
    localparam int NDIG  = WIDTH / DIGIT;
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);

    typedef enum logic {
        IDLE = 1'b0,
        CMP  = 1'b1
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             gi_q;
    logic             ei_q;
    logic             li_q;
    logic             busy_q;
    logic             done_q;
    logic             go_q;
    logic             eo_q;
    logic             lo_q;
    logic [DIGIT-1:0] dig_a;
    logic [DIGIT-1:0] dig_b;

    // Slice i counted from the top: shift it up into the MSBs, then take them.
    function automatic logic [DIGIT-1:0] digit_of(input logic [WIDTH-1:0] v,
                                                  input logic [IDX_W-1:0] i);
        logic [WIDTH-1:0] sh;
        sh = v << (i * DIGIT);
        return sh[WIDTH-1 -: DIGIT];
    endfunction

    // Current digit pair under examination.
    always_comb begin
        dig_a = digit_of(a_q, idx);
        dig_b = digit_of(b_q, idx);
    end

    // Handshake FSM: capture on accept, one digit per edge, registered verdict.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            idx    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            gi_q   <= 1'b0;
            ei_q   <= 1'b0;
            li_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            go_q   <= 1'b0;
            eo_q   <= 1'b0;
            lo_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_q    <= bus.a;
                        b_q    <= bus.b;
                        gi_q   <= bus.Gi;
                        ei_q   <= bus.Ei;
                        li_q   <= bus.Li;
                        idx    <= '0;
                        busy_q <= 1'b1;
                        state  <= CMP;
                    end
                end
                CMP: begin
                    if (!ei_q) begin
                        go_q   <= gi_q;
                        eo_q   <= 1'b0;
                        lo_q   <= li_q;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else if (dig_a > dig_b) begin
                        go_q   <= 1'b1;
                        eo_q   <= 1'b0;
                        lo_q   <= 1'b0;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else if (dig_a < dig_b) begin
                        go_q   <= 1'b0;
                        eo_q   <= 1'b0;
                        lo_q   <= 1'b1;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else if (idx == LAST_IDX) begin
                        go_q   <= 1'b0;
                        eo_q   <= 1'b1;
                        lo_q   <= 1'b0;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.Go   = go_q;
    assign bus.Eo   = eo_q;
    assign bus.Lo   = lo_q;
endmodule
